// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 width codes,
// FSM state encoding, byte-mask constants and small decode helpers used by
// both the controller (mem_lsu) and the lane aligner (mem_lsu_align).
package mem_lsu_pkg;

    // RV32I load/store width codes (funct3)
    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    // Unshifted byte-enable masks per access size
    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ACC0 = 3'd1,
        ST_ACC1 = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } lsu_state_e;

    // Byte mask for the size field funct3[1:0]; code 11 never reaches an access
    function automatic logic [3:0] size_mask(input logic [1:0] size_code);
        logic [3:0] mask_v;
        case (size_code)
            2'b00:   mask_v = MASK_B;
            2'b01:   mask_v = MASK_H;
            2'b10:   mask_v = MASK_W;
            default: mask_v = MASK_B;
        endcase
        return mask_v;
    endfunction

    // Number of bytes moved for the size field funct3[1:0]
    function automatic logic [2:0] size_bytes(input logic [1:0] size_code);
        logic [2:0] n_v;
        case (size_code)
            2'b00:   n_v = 3'd1;
            2'b01:   n_v = 3'd2;
            2'b10:   n_v = 3'd4;
            default: n_v = 3'd1;
        endcase
        return n_v;
    endfunction

    // True when the access spills past the end of its aligned word
    function automatic logic is_crossing(input logic [1:0] size_code,
                                         input logic [1:0] offset);
        return ({2'b00, offset} + {1'b0, size_bytes(size_code)}) > 4'd4;
    endfunction

    // Reserved width codes, and unsigned widths used with a store
    function automatic logic is_illegal_f3(input logic [2:0] funct3,
                                           input logic       we);
        logic bad_v;
        case (funct3)
            3'b011:  bad_v = 1'b1;
            3'b110:  bad_v = 1'b1;
            3'b111:  bad_v = 1'b1;
            default: bad_v = we & funct3[2];
        endcase
        return bad_v;
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Bundle of the pipeline-side request/response signals and the data_ram
// port signals of the load/store unit.
//   slave  : view of the LSU itself (takes requests, drives the RAM port)
//   master : view of the environment (pipeline + memory)
// Signals:
//   req_i, we_i, funct3_i, addr_i, wdata_i : request from the MEM stage
//   busy_o, done_o, rdata_o, err_o         : status/response to the MEM stage
//   ram_ce_o, ram_we_o, ram_addr_o,
//   ram_sel_o, ram_data_o                  : word-aligned RAM access
//   ram_data_i                             : RAM read data (same cycle)
interface mem_lsu_if;
    logic        req_i;
    logic        we_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        ram_ce_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [3:0]  ram_sel_o;
    logic [31:0] ram_data_o;
    logic [31:0] ram_data_i;

    modport slave (
        input  req_i, we_i, funct3_i, addr_i, wdata_i, ram_data_i,
        output busy_o, done_o, rdata_o, err_o,
               ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o
    );

    modport master (
        output req_i, we_i, funct3_i, addr_i, wdata_i, ram_data_i,
        input  busy_o, done_o, rdata_o, err_o,
               ram_ce_o, ram_we_o, ram_addr_o, ram_sel_o, ram_data_o
    );
endinterface

// File: rtl/mem_lsu_align.sv
// Combinational lane aligner for the load/store unit.
// For the current access (first or second word of a split access) it
// produces the byte enables and lane-shifted store data, and it moves the
// relevant read lanes to their position in the merged load result. It also
// sign/zero-extends the merged load value.
// Ports:
//   second_i    : 1 = second (upper) word of a crossing access
//   funct3_i    : latched width/sign code
//   offset_i    : latched byte offset addr[1:0]
//   wdata_i     : latched right-justified store data
//   ram_rdata_i : RAM read data for the current word
//   merge_i     : merged load value (low part from first word)
//   sel_o       : byte enables for the current word
//   wlane_o     : store data shifted to the current word's lanes
//   rlane_o     : read bytes shifted to their place in the result
//   ext_o       : extended load result built from merge_i
module mem_lsu_align
    import mem_lsu_pkg::*;
(
    input  logic        second_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] ram_rdata_i,
    input  logic [31:0] merge_i,
    output logic [3:0]  sel_o,
    output logic [31:0] wlane_o,
    output logic [31:0] rlane_o,
    output logic [31:0] ext_o
);

    logic [7:0] sel_wide_s;   // mask shifted across two words
    logic [4:0] up_sh_s;      // 8*offset
    logic [4:0] dn_sh_s;      // 8*(4-offset), mod 32

    assign sel_wide_s = {4'b0000, size_mask(funct3_i[1:0])} << offset_i;
    assign up_sh_s    = {offset_i, 3'b000};
    // 0 - 8*off in 5 bits equals 32 - 8*off for off = 1..3 (only case used)
    assign dn_sh_s    = 5'd0 - up_sh_s;

    // Pick lanes for the first word (low part) or the spilled upper word
    always_comb begin
        sel_o   = 4'b0000;
        wlane_o = 32'd0;
        rlane_o = 32'd0;
        if (second_i) begin
            sel_o   = sel_wide_s[7:4];
            wlane_o = wdata_i >> dn_sh_s;
            rlane_o = ram_rdata_i << dn_sh_s;
        end else begin
            sel_o   = sel_wide_s[3:0];
            wlane_o = wdata_i << up_sh_s;
            rlane_o = ram_rdata_i >> up_sh_s;
        end
    end

    // Width masking and sign/zero extension of the merged load value
    always_comb begin
        ext_o = 32'd0;
        case (funct3_i)
            LSU_B:   ext_o = {{24{merge_i[7]}}, merge_i[7:0]};
            LSU_H:   ext_o = {{16{merge_i[15]}}, merge_i[15:0]};
            LSU_W:   ext_o = merge_i;
            LSU_BU:  ext_o = {24'd0, merge_i[7:0]};
            LSU_HU:  ext_o = {16'd0, merge_i[15:0]};
            default: ext_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store initiator between the MEM stage and the data_ram port.
// One request becomes one word access, or two when the access crosses a
// word boundary (ALLOW_MISALIGNED=1); crossing accesses are rejected with
// err_o when ALLOW_MISALIGNED=0. busy_o stalls the pipeline until the
// one-cycle done_o pulse. All outputs decode from registered state; the
// RAM strobes are additionally gated by rst so a reset mid-access never
// writes.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   lsu      : mem_lsu_if.slave (request, response and RAM port signals)
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    mem_lsu_if.slave  lsu
);

    lsu_state_e  state_r;
    lsu_state_e  next_state_s;

    logic        we_r;
    logic [2:0]  funct3_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] merge_r;

    logic        accept_s;
    logic        illegal_s;
    logic        cur_cross_s;
    logic        second_s;
    logic [3:0]  sel_s;
    logic [31:0] wlane_s;
    logic [31:0] rlane_s;
    logic [31:0] ext_s;
    logic [31:0] word_addr_s;

    assign accept_s    = (state_r == ST_IDLE) && lsu.req_i;
    assign illegal_s   = is_illegal_f3(lsu.funct3_i, lsu.we_i) ||
                         (!ALLOW_MISALIGNED &&
                          is_crossing(lsu.funct3_i[1:0], lsu.addr_i[1:0]));
    assign cur_cross_s = is_crossing(funct3_r[1:0], addr_r[1:0]);
    assign second_s    = (state_r == ST_ACC1);
    assign word_addr_s = {addr_r[31:2], 2'b00};

    mem_lsu_align u_align (
        .second_i    (second_s),
        .funct3_i    (funct3_r),
        .offset_i    (addr_r[1:0]),
        .wdata_i     (wdata_r),
        .ram_rdata_i (lsu.ram_data_i),
        .merge_i     (merge_r),
        .sel_o       (sel_s),
        .wlane_o     (wlane_s),
        .rlane_o     (rlane_s),
        .ext_o       (ext_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Request capture on acceptance; load merge across the one or two accesses
    always_ff @(posedge clk) begin
        if (rst) begin
            we_r     <= 1'b0;
            funct3_r <= 3'b000;
            addr_r   <= 32'd0;
            wdata_r  <= 32'd0;
            merge_r  <= 32'd0;
        end else begin
            if (accept_s) begin
                we_r     <= lsu.we_i;
                funct3_r <= lsu.funct3_i;
                addr_r   <= lsu.addr_i;
                wdata_r  <= lsu.wdata_i;
            end
            // First word supplies the low bytes; the second ORs in the high ones
            if ((state_r == ST_ACC0) && !we_r) begin
                merge_r <= rlane_s;
            end else if ((state_r == ST_ACC1) && !we_r) begin
                merge_r <= merge_r | rlane_s;
            end
        end
    end

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (lsu.req_i) begin
                    if (illegal_s) begin
                        next_state_s = ST_ERR;
                    end else begin
                        next_state_s = ST_ACC0;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ACC0: begin
                if (cur_cross_s) begin
                    next_state_s = ST_ACC1;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            ST_ACC1: next_state_s = ST_DONE;
            ST_DONE: next_state_s = ST_IDLE;
            ST_ERR:  next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output decode from registered state; RAM strobes masked during reset
    always_comb begin
        lsu.busy_o     = (state_r != ST_IDLE);
        lsu.done_o     = 1'b0;
        lsu.err_o      = 1'b0;
        lsu.rdata_o    = 32'd0;
        lsu.ram_ce_o   = 1'b0;
        lsu.ram_we_o   = 1'b0;
        lsu.ram_addr_o = 32'd0;
        lsu.ram_sel_o  = 4'b0000;
        lsu.ram_data_o = 32'd0;
        case (state_r)
            ST_ACC0: begin
                lsu.ram_ce_o   = !rst;
                lsu.ram_we_o   = we_r && !rst;
                lsu.ram_addr_o = word_addr_s;
                lsu.ram_sel_o  = sel_s;
                lsu.ram_data_o = we_r ? wlane_s : 32'd0;
            end
            ST_ACC1: begin
                lsu.ram_ce_o   = !rst;
                lsu.ram_we_o   = we_r && !rst;
                lsu.ram_addr_o = word_addr_s + 32'd4;
                lsu.ram_sel_o  = sel_s;
                lsu.ram_data_o = we_r ? wlane_s : 32'd0;
            end
            ST_DONE: begin
                lsu.done_o  = 1'b1;
                lsu.rdata_o = we_r ? 32'd0 : ext_s;
            end
            ST_ERR: begin
                lsu.done_o = 1'b1;
                lsu.err_o  = 1'b1;
            end
            default: begin
                lsu.done_o = 1'b0;
            end
        endcase
    end

endmodule
